// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the multi-cycle memory port: registered request
// fields towards the memory, read data and completion pulse back.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Access unit side: issues requests, receives data and ack.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  // Memory side: accepts requests, returns data and ack.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle memory port below the control FSM. Converts the FSM's
// IRWrite/MemR/MemW/IoD strobes into a single req/ack transaction on a
// variable-latency word memory, holds IR and MDR, and stalls the FSM
// while a transaction is outstanding.
//
// state  | meaning
// IDLE   | no transaction; a strobe captures type/address and issues req
// WAIT   | req outstanding; ends on ack or after TIMEOUT cycles without one
// DONE   | one cycle with stall low so the FSM can advance; strobes ignored
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ctl_IoD,
  input  logic              ctl_IRWrite,
  input  logic              ctl_MemR,
  input  logic              ctl_MemW,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] wdata_in,
  mem_access_unit_if.master mem,
  output logic [DATA_W-1:0] ir_out,
  output logic [6:0]        ctl_field_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              mem_stall,
  output logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {T_FETCH, T_READ, T_WRITE} xfer_t;

  // The counter holds the number of WAIT cycles already spent, so the
  // abort fires in the TIMEOUT-th WAIT cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  xfer_t      xfer;
  logic [7:0] cnt;
  logic       acc;
  logic       illegal;
  xfer_t      xfer_next;

  // Strobe decode: request present, illegal combination, and the type by priority.
  always_comb begin
    acc       = ctl_IRWrite | ctl_MemR | ctl_MemW;
    illegal   = (ctl_MemW & (ctl_MemR | ctl_IRWrite)) | (ctl_MemR & ctl_IRWrite);
    xfer_next = T_READ;
    if (ctl_MemW)
      xfer_next = T_WRITE;
    else if (ctl_IRWrite)
      xfer_next = T_FETCH;
  end

  assign mem_stall     = ((state == S_IDLE) & acc) | (state == S_WAIT);
  assign ctl_field_out = ir_out[6:0];

  // Transaction FSM with registered bus outputs, IR/MDR and sticky error.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= S_IDLE;
      xfer          <= T_FETCH;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      ir_out        <= '0;
      mdr_out       <= '0;
      mem_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= ctl_MemW;
            mem.mem_addr  <= ctl_IoD ? alu_out_in : pc_in;
            mem.mem_wdata <= wdata_in;
            xfer          <= xfer_next;
            cnt           <= '0;
            if (illegal)
              mem_err <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack) begin
            case (xfer)
              T_FETCH: ir_out  <= mem.mem_rdata;
              T_READ:  mdr_out <= mem.mem_rdata;
              default: ;
            endcase
            mem.mem_req <= 1'b0;
            state       <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            case (xfer)
              T_FETCH: ir_out  <= '1;
              T_READ:  mdr_out <= '1;
              default: ;
            endcase
            mem.mem_req <= 1'b0;
            mem_err     <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: the driver issues transactions and pushes the
// expected bus request and the expected end-of-transaction register state
// into queues; a negedge monitor pops and compares them as the DUT shows
// a new request or leaves its stall.
module tb_mem_access_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          iod, irw, memr, memw;
  logic [AW-1:0] pc, alu;
  logic [DW-1:0] wd;
  logic [DW-1:0] ir, mdr;
  logic [6:0]    fld;
  logic          stall, err;

  mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK           (clk),
    .Reset         (rst),
    .ctl_IoD       (iod),
    .ctl_IRWrite   (irw),
    .ctl_MemR      (memr),
    .ctl_MemW      (memw),
    .pc_in         (pc),
    .alu_out_in    (alu),
    .wdata_in      (wd),
    .mem           (bus),
    .ir_out        (ir),
    .ctl_field_out (fld),
    .mdr_out       (mdr),
    .mem_stall     (stall),
    .mem_err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic [DW-1:0] ir;
    logic [DW-1:0] mdr;
    logic          err;
    int            stalls;
  } res_t;

  req_t req_q[$];
  res_t res_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Architectural model state after every issued transaction.
  logic [DW-1:0] ir_m  = '0;
  logic [DW-1:0] mdr_m = '0;
  logic          err_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction from IDLE. lat = WAIT cycle carrying the ack (1 = first),
  // lat = 0 means the memory never answers.
  task automatic do_txn(input logic s_ir, input logic s_r, input logic s_w, input logic s_iod,
                        input int lat, input logic [AW-1:0] a_pc, input logic [AW-1:0] a_alu,
                        input logic [DW-1:0] a_wd, input logic [DW-1:0] a_rd);
    req_t rq;
    res_t rs;
    int   kind;
    int   n;
    irw = s_ir; memr = s_r; memw = s_w; iod = s_iod;
    pc = a_pc; alu = a_alu; wd = a_wd;
    rq.addr  = s_iod ? a_alu : a_pc;
    rq.we    = s_w;
    rq.wdata = a_wd;
    req_q.push_back(rq);
    kind = s_w ? 2 : (s_ir ? 0 : 1);
    if ((s_w && (s_r || s_ir)) || (s_r && s_ir))
      err_m = 1'b1;
    if (lat == 0) begin
      err_m = 1'b1;
      if (kind == 0) ir_m = '1;
      else if (kind == 1) mdr_m = '1;
      rs.stalls = 1 + TO;
    end else begin
      if (kind == 0) ir_m = a_rd;
      else if (kind == 1) mdr_m = a_rd;
      rs.stalls = 1 + lat;
    end
    rs.ir = ir_m; rs.mdr = mdr_m; rs.err = err_m;
    res_q.push_back(rs);
    tick();
    n = (lat == 0) ? TO : lat;
    for (int k = 1; k <= n; k++) begin
      pc  = AW'($urandom);
      alu = AW'($urandom);
      wd  = DW'($urandom);
      bus.mem_ack   = (lat != 0) && (k == lat);
      bus.mem_rdata = ((lat != 0) && (k == lat)) ? a_rd : DW'($urandom);
      tick();
    end
    bus.mem_ack = 1'b0;
    tick();
    irw = 1'b0; memr = 1'b0; memw = 1'b0;
  endtask

  task automatic spurious_ack();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = DW'($urandom);
    tick();
    bus.mem_ack = 1'b0;
  endtask

  // Fetch interrupted by reset in its second WAIT cycle, ack one cycle later.
  task automatic reset_mid_wait();
    req_t rq;
    irw = 1'b1; memr = 1'b0; memw = 1'b0; iod = 1'b0;
    pc = AW'($urandom);
    rq.addr = pc; rq.we = 1'b0; rq.wdata = wd;
    req_q.push_back(rq);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    irw = 1'b0;
    ir_m = '0; mdr_m = '0; err_m = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = DW'($urandom);
    tick();
    bus.mem_ack = 1'b0;
  endtask

  // Monitor state.
  logic [DW-1:0] exp_ir  = '0;
  logic [DW-1:0] exp_mdr = '0;
  logic          exp_err = 1'b0;
  logic          prev_stall = 1'b0;
  logic          prev_req   = 1'b0;
  logic          after_rst  = 1'b0;
  int            scnt = 0;
  req_t          held;
  req_t          mrq;
  res_t          mrs;

  // Scoreboard monitor: requests on rising mem_req, results on stall release.
  always @(negedge clk) begin
    if (rst) begin
      exp_ir = '0; exp_mdr = '0; exp_err = 1'b0;
      prev_stall = 1'b0; prev_req = 1'b0; scnt = 0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("rst_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_we", 32'(bus.mem_we), 32'h0);
        after_rst = 1'b0;
      end
      if (bus.mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'(bus.mem_req), 32'h0);
        end else begin
          mrq = req_q.pop_front();
          chk("req_addr", 32'(bus.mem_addr), 32'(mrq.addr));
          chk("req_we", 32'(bus.mem_we), 32'(mrq.we));
          chk("req_wdata", 32'(bus.mem_wdata), 32'(mrq.wdata));
          held = mrq;
        end
      end else if (bus.mem_req) begin
        chk("hold_addr", 32'(bus.mem_addr), 32'(held.addr));
        chk("hold_we", 32'(bus.mem_we), 32'(held.we));
        chk("hold_wdata", 32'(bus.mem_wdata), 32'(held.wdata));
      end
      if (stall) begin
        scnt++;
      end else if (prev_stall) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", 32'(prev_stall), 32'h0);
        end else begin
          mrs = res_q.pop_front();
          chk("done_ir", 32'(ir), 32'(mrs.ir));
          chk("done_field", 32'(fld), 32'(mrs.ir[6:0]));
          chk("done_mdr", 32'(mdr), 32'(mrs.mdr));
          chk("done_err", 32'(err), 32'(mrs.err));
          chk("done_stalls", 32'(scnt), 32'(mrs.stalls));
          chk("done_req", 32'(bus.mem_req), 32'h0);
          exp_ir = mrs.ir; exp_mdr = mrs.mdr; exp_err = mrs.err;
        end
        scnt = 0;
      end else begin
        chk("idle_req", 32'(bus.mem_req), 32'h0);
        chk("idle_ir", 32'(ir), 32'(exp_ir));
        chk("idle_mdr", 32'(mdr), 32'(exp_mdr));
        chk("idle_err", 32'(err), 32'(exp_err));
      end
      prev_stall = stall;
      prev_req   = bus.mem_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] s;
    int         lat;
    rst = 1'b1;
    iod = 1'b0; irw = 1'b0; memr = 1'b0; memw = 1'b0;
    pc = '0; alu = '0; wd = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 1, 16'h0010, 16'h0000, 16'h0000, 16'h1A0A);
    tick();
    do_txn(1'b0, 1'b1, 1'b0, 1'b1, 3, 16'h0000, 16'h0200, 16'h0000, 16'hBEEF);
    do_txn(1'b0, 1'b0, 1'b1, 1'b1, 4, 16'h0000, 16'h0300, 16'h1234, 16'h5555);
    tick();
    spurious_ack();
    tick();
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0040, 16'h0000, 16'h0000, 16'h0000);
    tick();
    do_txn(0, 1, 0, 1, 1, 16'h0000, 16'h0400, 16'h0000, 16'h0F0F);
    tick();
    reset_mid_wait();
    tick();
    do_txn(1'b0, 1'b1, 1'b1, 1'b1, 1, 16'h0000, 16'h0500, 16'hCAFE, 16'h7777);
    tick();

    for (int i = 0; i < 150; i++) begin
      s   = 3'($urandom_range(1, 7));
      lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        reset_mid_wait();
      end else begin
        do_txn(s[0], s[1], s[2], 1'($urandom), lat, AW'($urandom), AW'($urandom),
               DW'($urandom), DW'($urandom));
      end
      case ($urandom_range(0, 3))
        0: ;
        1: tick();
        2: spurious_ack();
        default: begin tick(); tick(); end
      endcase
    end

    repeat (3) tick();
    chk("req_q_empty", 32'(req_q.size()), 32'h0);
    chk("res_q_empty", 32'(res_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
